// File: rtl/lfsr_gen_pkg.sv
// Shared definitions for lfsr_gen: mode encoding and default tap masks per width.
// Build option: LFSR_GEN_LOCKUP_RECOVER_EN (see lfsr_gen.sv).
package lfsr_gen_pkg;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } mode_e;

  // Fibonacci masks tap state[i] into the shifted-in bit; Galois masks are the
  // low polynomial terms toggled when a 1 leaves the MSB.
  localparam logic [3:0]  FTAPS_W4  = 4'b1100;
  localparam logic [3:0]  GTAPS_W4  = 4'b0011;
  localparam logic [7:0]  FTAPS_W8  = 8'hB8;
  localparam logic [7:0]  GTAPS_W8  = 8'h1D;
  localparam logic [15:0] FTAPS_W16 = 16'hD008;
  localparam logic [15:0] GTAPS_W16 = 16'h002D;
  localparam logic [31:0] FTAPS_W32 = 32'h8020_0003;
  localparam logic [31:0] GTAPS_W32 = 32'h0040_0007;

endpackage

// File: rtl/lfsr_gen_stepper.sv
// Combinational single LFSR step in Fibonacci or Galois form.
module lfsr_gen_stepper
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  FTAPS = 4'b1100,
  parameter logic [WIDTH-1:0]  GTAPS = 4'b0011
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             mode,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = '0;
    if (mode_e'(mode) == MODE_GAL) begin
      nxt = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? GTAPS : '0);
    end else begin
      nxt = {cur[WIDTH-2:0], ^(cur & FTAPS)};
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with parallel advance, seed load, period pulse and lockup flag.
// Build option: define LFSR_GEN_LOCKUP_RECOVER_EN to replace zero seeds with SEED.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  FTAPS = 4'b1100,
  parameter logic [WIDTH-1:0]  GTAPS = 4'b0011,
  parameter logic [WIDTH-1:0]  SEED  = 4'b1111,
  parameter int unsigned       STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic [WIDTH-1:0] step_cnt,
  output logic             period_pulse,
  output logic             lockup
);

`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  logic [WIDTH-1:0]            seed_reg;
  logic [WIDTH-1:0]            load_val;
  logic [STEPS:0][WIDTH-1:0]   chain;

  assign chain[0] = state;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_gen_stepper #(
      .WIDTH (WIDTH),
      .FTAPS (FTAPS),
      .GTAPS (GTAPS)
    ) u_step (
      .cur  (chain[g]),
      .mode (mode),
      .nxt  (chain[g+1])
    );
  end

  assign load_val = (RECOVER && seed_in == '0) ? SEED : seed_in;
  assign bit_out  = state[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEED;
      seed_reg     <= SEED;
      step_cnt     <= '0;
      period_pulse <= 1'b0;
      lockup       <= 1'b0;
    end else if (load) begin
      state        <= load_val;
      seed_reg     <= load_val;
      step_cnt     <= '0;
      period_pulse <= 1'b0;
      lockup       <= !RECOVER && (load_val == '0);
    end else if (en) begin
      state  <= chain[STEPS];
      lockup <= !RECOVER && (chain[STEPS] == '0);
      if (chain[STEPS] == seed_reg) begin
        period_pulse <= 1'b1;
        step_cnt     <= '0;
      end else begin
        period_pulse <= 1'b0;
        step_cnt     <= step_cnt + WIDTH'(1);
      end
    end else begin
      period_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed sequences plus randomized traffic
// against an arithmetic reference model, for STEPS=1 and STEPS=4 instances.
module tb_lfsr_gen;

  localparam int FT = 12;   // taps on state[3], state[2]
  localparam int GT = 3;    // toggle mask
  localparam int SD = 15;   // reset seed

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [3:0] seed_in;
  logic [3:0] st  [2];
  logic       bo  [2];
  logic [3:0] cnt [2];
  logic       pp  [2];
  logic       lk  [2];

  int checks = 0;
  int errors = 0;

  int m_st [2];
  int m_sd [2];
  int m_cnt[2];
  int m_pp [2];

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .STEPS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .seed_in(seed_in),
    .state(st[0]), .bit_out(bo[0]), .step_cnt(cnt[0]), .period_pulse(pp[0]), .lockup(lk[0])
  );

  lfsr_gen #(.WIDTH(4), .STEPS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .seed_in(seed_in),
    .state(st[1]), .bit_out(bo[1]), .step_cnt(cnt[1]), .period_pulse(pp[1]), .lockup(lk[1])
  );

  function automatic int fib_step(int s);
    int ones = 0;
    for (int i = 0; i < 4; i++) if ((((s & FT) >> i) & 1) == 1) ones++;
    return ((s * 2) % 16) + (ones % 2);
  endfunction

  function automatic int gal_step(int s);
    int r = (s * 2) % 16;
    if (s >= 8) r = r ^ GT;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic e, input logic md,
                     input logic [3:0] sd);
    int v, nx, n;
    rst = r; load = l; en = e; mode = md; seed_in = sd;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 1 : 4;
      if (r) begin
        m_st[k] = SD; m_sd[k] = SD; m_cnt[k] = 0; m_pp[k] = 0;
      end else if (l) begin
        v = int'(sd);
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
        if (v == 0) v = SD;
`endif
        m_st[k] = v; m_sd[k] = v; m_cnt[k] = 0; m_pp[k] = 0;
      end else if (e) begin
        nx = m_st[k];
        for (int i = 0; i < n; i++) nx = md ? gal_step(nx) : fib_step(nx);
        if (nx == m_sd[k]) begin
          m_pp[k] = 1; m_cnt[k] = 0;
        end else begin
          m_pp[k] = 0; m_cnt[k] = (m_cnt[k] + 1) % 16;
        end
        m_st[k] = nx;
      end else begin
        m_pp[k] = 0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_state%0d", k), 32'(st[k]), 32'(m_st[k]));
      check($sformatf("model_bit%0d", k), 32'(bo[k]), 32'(m_st[k] / 8));
      check($sformatf("model_cnt%0d", k), 32'(cnt[k]), 32'(m_cnt[k]));
      check($sformatf("model_pulse%0d", k), 32'(pp[k]), 32'(m_pp[k]));
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
      check($sformatf("model_lock%0d", k), 32'(lk[k]), 32'd0);
`else
      check($sformatf("model_lock%0d", k), 32'(lk[k]), 32'(m_st[k] == 0));
`endif
    end
  endtask

  logic [3:0] fib_tbl [15] = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001,
                               4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                               4'b1111};
  logic [3:0] gal_tbl [15] = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1011,
                               4'b0101, 4'b1010, 4'b0111, 4'b1110, 4'b1111, 4'b1101, 4'b1001,
                               4'b0001};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; seed_in = '0;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = SD; m_sd[k] = SD; m_cnt[k] = 0; m_pp[k] = 0;
    end

    cyc(1, 0, 0, 0, 4'h0);
    check("rst_state", 32'(st[0]), 32'hF);
    check("rst_cnt", 32'(cnt[0]), 32'h0);
    check("rst_pulse", 32'(pp[0]), 32'h0);
    check("rst_lock", 32'(lk[0]), 32'h0);

    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 1, 0, 4'h0);
      check("fib_seq", 32'(st[0]), 32'(fib_tbl[i]));
      check("fib_pulse", 32'(pp[0]), 32'(i == 14));
      check("fib_cnt", 32'(cnt[0]), (i == 14) ? 32'd0 : 32'(i + 1));
    end

    cyc(0, 1, 0, 1, 4'b0001);
    check("gal_load", 32'(st[0]), 32'h1);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 1, 1, 4'h0);
      check("gal_seq", 32'(st[0]), 32'(gal_tbl[i]));
      check("gal_pulse", 32'(pp[0]), 32'(i == 14));
    end

    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, $urandom_range(1), 4'($urandom_range(15)));
      check("hold_state", 32'(st[0]), 32'h1);
      check("hold_cnt", 32'(cnt[0]), 32'h0);
      check("hold_pulse", 32'(pp[0]), 32'h0);
    end

    cyc(0, 1, 1, 0, 4'b1010);
    check("prio_state", 32'(st[0]), 32'hA);
    check("prio_cnt", 32'(cnt[0]), 32'h0);

    // Parallel advance: each enable moves four single steps from 1111.
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 1, 0, 4'h0);
    check("steps4_1", 32'(st[1]), 32'b0001);
    cyc(0, 0, 1, 0, 4'h0);
    check("steps4_2", 32'(st[1]), 32'b0011);
    cyc(0, 0, 1, 0, 4'h0);
    check("steps4_3", 32'(st[1]), 32'b0101);

    cyc(0, 1, 0, 0, 4'h0);
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
    check("zero_state", 32'(st[0]), 32'hF);
    check("zero_lock", 32'(lk[0]), 32'h0);
`else
    check("zero_state", 32'(st[0]), 32'h0);
    check("zero_lock", 32'(lk[0]), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, i % 2, 4'h0);
      check("zero_hold", 32'(st[0]), 32'h0);
      check("zero_pulse", 32'(pp[0]), 32'h1);
      check("zero_lock_en", 32'(lk[0]), 32'h1);
    end
`endif

    cyc(1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 4'h0);
    check("mid_state", 32'(st[0]), 32'b0110);
    cyc(1, 1, 1, 0, 4'h5);
    check("mid_rst_state", 32'(st[0]), 32'hF);
    check("mid_rst_cnt", 32'(cnt[0]), 32'h0);
    check("mid_rst_pulse", 32'(pp[0]), 32'h0);
    cyc(0, 0, 1, 0, 4'h0);
    check("mid_restart", 32'(st[0]), 32'b1110);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(49) == 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
          $urandom_range(1), ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
